// File: rtl/phase_frame_sequencer_if.sv
// Host byte-stream handshake between the FT FIFO reader and the phase sequencer.
// A byte transfers on a clock where rx_valid and rx_ready are both high.
interface phase_frame_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/phase_frame_sequencer.sv
// Parses host commands into a shadow phase bank and swaps it into the active bank atomically.
// Define PHASE_SEQ_IMMEDIATE_COMMIT_EN to commit on the COMMIT byte instead of waiting for sync_tick.
module phase_frame_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int PHASE_W        = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                   sys_clk,
  input  logic                                   ext_rst,
  phase_frame_sequencer_if.slave                 rx,
  input  logic                                   sync_tick,
  output logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   phases,
  output logic                                   commit_pending,
  output logic                                   read_error,
  output logic [15:0]                            frame_count
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_COMMIT = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GET_CHAN,
    S_GET_PHASE,
    S_WAIT_SYNC
  } state_t;

  state_t                                r_state;
  logic                                  r_rx_ready;
  logic [CH_W-1:0]                       r_chan;
  logic                                  r_chan_ok;
  logic [TO_W-1:0]                       r_timeout;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0]  r_shadow;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0]  r_phases;
  logic                                  r_commit_pending;
  logic                                  r_read_error;
  logic [15:0]                           r_frame_count;

  logic w_xfer;
  logic w_chan_in_range;
  logic w_timeout_hit;

  assign w_xfer          = rx.rx_valid & r_rx_ready;
  assign w_chan_in_range = {24'd0, rx.rx_data} < 32'(NUM_CHANNELS);
  assign w_timeout_hit   = (r_timeout == TO_LAST);

`ifdef PHASE_SEQ_IMMEDIATE_COMMIT_EN
  logic w_unused_sync_tick;
  assign w_unused_sync_tick = sync_tick;
`endif

  always_ff @(posedge sys_clk or posedge ext_rst) begin
    if (ext_rst) begin
      r_state          <= S_IDLE;
      r_rx_ready       <= 1'b0;
      r_chan           <= '0;
      r_chan_ok        <= 1'b0;
      r_timeout        <= '0;
      // NOTE: the shadow bank is a handful of flops, not a RAM, and must read back as
      // zero after reset, so it sits in the reset branch like any other state.
      r_shadow         <= '0;
      r_phases         <= '0;
      r_commit_pending <= 1'b0;
      r_read_error     <= 1'b0;
      r_frame_count    <= '0;
    end else begin
      // NOTE: every assignment here is non-blocking so all registers update from the
      // same pre-edge values; a blocking '=' would leak new values into later reads.
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          r_timeout  <= '0;
          if (w_xfer) begin
            case (rx.rx_data)
              CMD_WRITE: r_state <= S_GET_CHAN;
              CMD_COMMIT: begin
`ifdef PHASE_SEQ_IMMEDIATE_COMMIT_EN
                r_phases      <= r_shadow;
                r_frame_count <= r_frame_count + 16'd1;
`else
                r_state          <= S_WAIT_SYNC;
                r_rx_ready       <= 1'b0;
                r_commit_pending <= 1'b1;
`endif
              end
              CMD_CLEAR: begin
                r_shadow     <= '0;
                r_phases     <= '0;
                r_read_error <= 1'b0;
              end
              default: r_read_error <= 1'b1;
            endcase
          end
        end

        S_GET_CHAN: begin
          if (w_xfer) begin
            r_chan    <= rx.rx_data[CH_W-1:0];
            r_chan_ok <= w_chan_in_range;
            if (!w_chan_in_range) r_read_error <= 1'b1;
            r_state   <= S_GET_PHASE;
            r_timeout <= '0;
          end else if (w_timeout_hit) begin
            r_read_error <= 1'b1;
            r_state      <= S_IDLE;
            r_timeout    <= '0;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end

        S_GET_PHASE: begin
          // An out-of-range channel still consumes its phase byte to keep packet framing.
          if (w_xfer) begin
            if (r_chan_ok) r_shadow[r_chan] <= rx.rx_data;
            r_state   <= S_IDLE;
            r_timeout <= '0;
          end else if (w_timeout_hit) begin
            r_read_error <= 1'b1;
            r_state      <= S_IDLE;
            r_timeout    <= '0;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end

`ifndef PHASE_SEQ_IMMEDIATE_COMMIT_EN
        S_WAIT_SYNC: begin
          if (sync_tick) begin
            r_phases         <= r_shadow;
            r_frame_count    <= r_frame_count + 16'd1;
            r_commit_pending <= 1'b0;
            r_rx_ready       <= 1'b1;
            r_state          <= S_IDLE;
          end
        end
`endif

        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b1;
          r_timeout  <= '0;
        end
      endcase
    end
  end

  assign rx.rx_ready     = r_rx_ready;
  assign phases          = r_phases;
  assign commit_pending  = r_commit_pending;
  assign read_error      = r_read_error;
  assign frame_count     = r_frame_count;

endmodule

// File: tb/tb_phase_frame_sequencer.sv
// Directed bench for phase_frame_sequencer: command parsing, sync-aligned commit, errors, timeout, reset.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_phase_frame_sequencer;

  logic        clk;
  logic        rst;
  logic        sync_tick;
  logic [3:0][7:0] phases;
  logic        commit_pending;
  logic        read_error;
  logic [15:0] frame_count;

  int n_vec;
  int n_err;
  int exp_frames;

  phase_frame_sequencer_if u_if ();

  phase_frame_sequencer #(
    .NUM_CHANNELS   (4),
    .PHASE_W        (8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .sys_clk        (clk),
    .ext_rst        (rst),
    .rx             (u_if.slave),
    .sync_tick      (sync_tick),
    .phases         (phases),
    .commit_pending (commit_pending),
    .read_error     (read_error),
    .frame_count    (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; the byte is held until the DUT accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    n = 0;
    while (u_if.rx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_ready_timeout", {31'd0, u_if.rx_ready}, 32'd1);
    @(negedge clk);
    u_if.rx_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    sync_tick = 1'b1;
    @(negedge clk);
    sync_tick = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] exp_phases);
    send_byte(8'h02);
`ifdef PHASE_SEQ_IMMEDIATE_COMMIT_EN
    @(negedge clk);
`else
    check("commit_pending_set", {31'd0, commit_pending}, 32'd1);
    check("rx_ready_in_wait", {31'd0, u_if.rx_ready}, 32'd0);
    pulse_tick();
    check("commit_pending_clr", {31'd0, commit_pending}, 32'd0);
`endif
    exp_frames++;
    check("commit_frames", {16'd0, frame_count}, exp_frames);
    check("commit_phases", phases, exp_phases);
  endtask

  initial begin
    int bad;
    n_vec = 0;
    n_err = 0;
    exp_frames = 0;
    rst = 1'b1;
    sync_tick = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, u_if.rx_ready}, 32'd0);
    check("rst_phases", phases, 32'd0);
    check("rst_pending", {31'd0, commit_pending}, 32'd0);
    check("rst_error", {31'd0, read_error}, 32'd0);
    check("rst_frames", {16'd0, frame_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, u_if.rx_ready}, 32'd1);

    // Test 1: write channel 1 = 0x40, commit, tick later
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h40);
    check("t1_active_untouched", phases, 32'd0);
    send_byte(8'h02);
`ifdef PHASE_SEQ_IMMEDIATE_COMMIT_EN
    check("t1_imm_before", phases, 32'd0);
    @(negedge clk);
    check("t1_imm_phases", phases, 32'h0000_4000);
    check("t1_imm_pending", {31'd0, commit_pending}, 32'd0);
`else
    check("t1_pending", {31'd0, commit_pending}, 32'd1);
    repeat (10) @(negedge clk);
    check("t1_wait_phases", phases, 32'd0);
    check("t1_wait_pending", {31'd0, commit_pending}, 32'd1);
    sync_tick = 1'b1;
    check("t1_tick_cycle", phases, 32'd0);
    @(negedge clk);
    sync_tick = 1'b0;
    check("t1_phases", phases, 32'h0000_4000);
    check("t1_pending_clr", {31'd0, commit_pending}, 32'd0);
    check("t1_ready", {31'd0, u_if.rx_ready}, 32'd1);
`endif
    exp_frames++;
    check("t1_frames", {16'd0, frame_count}, exp_frames);

    // Test 2: commit held without tick while a byte waits
`ifdef PHASE_SEQ_IMMEDIATE_COMMIT_EN
    send_byte(8'h01);
`else
    send_byte(8'h02);
    u_if.rx_data  = 8'h01;
    u_if.rx_valid = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (u_if.rx_ready !== 1'b0) bad++;
    end
    check("t2_ready_held_low", bad, 32'd0);
    check("t2_frames_held", {16'd0, frame_count}, exp_frames);
    pulse_tick();
    exp_frames++;
    check("t2_ready_after_tick", {31'd0, u_if.rx_ready}, 32'd1);
    check("t2_frames", {16'd0, frame_count}, exp_frames);
    @(negedge clk);
    u_if.rx_valid = 1'b0;
`endif
    send_byte(8'h02);
    send_byte(8'h33);
    do_commit(32'h0033_4000);

    // Test 3: out-of-range channel keeps framing, then CLEAR
    send_byte(8'h01);
    send_byte(8'h07);
    check("t3_error", {31'd0, read_error}, 32'd1);
    send_byte(8'hAA);
    do_commit(32'h0033_4000);
    send_byte(8'h03);
    check("t3_clear_error", {31'd0, read_error}, 32'd0);
    check("t3_clear_phases", phases, 32'd0);
    do_commit(32'd0);

    // Test 4: unknown command, then a valid packet
    send_byte(8'h55);
    check("t4_error", {31'd0, read_error}, 32'd1);
    check("t4_ready", {31'd0, u_if.rx_ready}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    do_commit(32'h0000_0011);
    check("t4_error_sticky", {31'd0, read_error}, 32'd1);

    // Test 5: stall mid-packet until timeout
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (15) @(negedge clk);
    check("t5_no_error_yet", {31'd0, read_error}, 32'd0);
    @(negedge clk);
    check("t5_timeout_error", {31'd0, read_error}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h77);
    do_commit(32'h7700_0000);

    // sync_tick outside a pending commit does nothing
    pulse_tick();
    check("idle_tick_frames", {16'd0, frame_count}, exp_frames);
    check("idle_tick_phases", phases, 32'h7700_0000);

    // Test 6: tick coincident with COMMIT ignored, then async reset mid-wait
`ifndef PHASE_SEQ_IMMEDIATE_COMMIT_EN
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h99);
    sync_tick = 1'b1;
    send_byte(8'h02);
    sync_tick = 1'b0;
    check("t6_same_cycle_tick", {31'd0, commit_pending}, 32'd1);
    check("t6_same_cycle_frames", {16'd0, frame_count}, exp_frames);
`endif
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, u_if.rx_ready}, 32'd0);
    check("t6_rst_pending", {31'd0, commit_pending}, 32'd0);
    check("t6_rst_phases", phases, 32'd0);
    check("t6_rst_frames", {16'd0, frame_count}, 32'd0);
    check("t6_rst_error", {31'd0, read_error}, 32'd0);
    exp_frames = 0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_release_ready", {31'd0, u_if.rx_ready}, 32'd0);
    @(negedge clk);
    check("t6_ready_after", {31'd0, u_if.rx_ready}, 32'd1);
    do_commit(32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
